// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter, its FIFO and the receiver debug port.
package uart_pkg;

    localparam int DEFAULT_DELAY_FRAMES = 234;  // 27 MHz / 115200 baud
    localparam int UART_DATA_W          = 8;

    // Line FSM encoding; the receiver exposes the same values on its debug bus.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; push when full and pop when empty are ignored.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; count tracks net occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_stream.sv
// Buffered 8N1 UART transmitter: valid/ready byte input, FIFO, back-to-back framing.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [UART_DATA_W-1:0]        tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_done
);

    localparam int                CTR_W     = $clog2(DELAY_FRAMES);
    localparam logic [CTR_W-1:0]  BAUD_LAST = CTR_W'(DELAY_FRAMES - 1);

    uart_state_e             state, state_d;
    logic [CTR_W-1:0]        baud_cnt, baud_d;
    logic [2:0]              bit_idx, bit_d;
    logic [UART_DATA_W-1:0]  shift, shift_d;
    logic                    line_d;
    logic                    baud_last;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic [UART_DATA_W-1:0]  fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;

    assign tx_ready  = !fifo_full;
    assign fifo_push = tx_valid && tx_ready;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign baud_last = (baud_cnt == BAUD_LAST);

    uart_sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Line state register; uart_tx is registered so the pin never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_idx  <= bit_d;
            shift    <= shift_d;
            uart_tx  <= line_d;
        end
    end

    // Next-state logic: each bit lasts DELAY_FRAMES cycles; the stop bit's last
    // cycle pops the next byte straight into a start bit when one is waiting.
    always_comb begin
        state_d  = state;
        baud_d   = baud_cnt + CTR_W'(1);
        bit_d    = bit_idx;
        shift_d  = shift;
        line_d   = uart_tx;
        fifo_pop = 1'b0;
        tx_done  = 1'b0;
        unique case (state)
            IDLE: begin
                baud_d = '0;
                line_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    line_d   = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    line_d  = shift[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx == 3'd7) begin
                        line_d  = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d = {1'b0, shift[UART_DATA_W-1:1]};
                        bit_d   = bit_idx + 3'd1;
                        line_d  = shift[1];
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_done = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        line_d   = 1'b0;
                        state_d  = START;
                    end else begin
                        line_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

endmodule
